ws2812_tx: RTL
==============

Name: ws2812_tx

Overview:
- Serial line driver for the WS2812 LED chain, directly downstream of the pixel-to-WS2812 gating stage.
- Issues a per-pixel request level `ws2812_data_req` and captures one 24-bit GRB word per request.
- Shifts the word MSB-first onto the single-wire `ws2812_dout` using WS2812 NRZ pulse-width coding.
- Holds the line low while no data arrives; the upstream stage withholds data to form the >=280 us latch/reset gap.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; informational only, timing counts below assume 50 MHz.
- T0H, 8'd20, high cycles for a '0' bit (0.40 us).
- T1H, 8'd40, high cycles for a '1' bit (0.80 us).
- TBIT, 8'd63, total cycles per bit (1.26 us). Required: 0 < T0H < T1H < TBIT <= 255.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- ws2812_data_req  output  1  level request for the next pixel word; high only in state REQ
- ws2812_data  input  24  pixel word, GRB order, bit 23 sent first
- ws2812_data_vld  input  1  valid; a rising edge while in REQ captures ws2812_data
- ws2812_dout  output  1  registered serial line to the first LED DIN
- busy  output  1  high in state SEND
- pixel_done  output  1  one-cycle pulse on the final cycle of bit 0 of each pixel

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register, bit index and cycle counter all 0.
- Reset is asynchronous: when rst asserts mid-frame, ws2812_dout drops to 0 immediately and any partial pixel is discarded.
- `vld_d` is `ws2812_data_vld` registered. `vld_rise = ws2812_data_vld & ~vld_d`.
- States: IDLE, REQ, SEND.
- IDLE:
  - Lasts exactly one cycle after reset release, then goes to REQ.
  - This guarantees a clean 0->1 edge on ws2812_data_req, which upstream counts.
- REQ:
  - ws2812_data_req=1, ws2812_dout=0.
  - On vld_rise in cycle N: latch ws2812_data into shr[23:0], set bit_idx=23 and cyc=0, and enter SEND at N+1.
  - At N+1: ws2812_data_req=0, ws2812_dout=1. Capture-to-line-high latency is 1 cycle.
  - A vld that stays high, or a vld rise outside REQ, is ignored; no capture occurs.
  - The stay in REQ is unbounded; the line stays low throughout, and that low period forms the reset/latch gap.
- SEND:
  - cyc counts 0..TBIT-1.
  - ws2812_dout = 1 while cyc < (shr[23] ? T1H : T0H), else 0. The output is registered, so the high time is exactly T1H or T0H cycles.
  - At cyc==TBIT-1 with bit_idx>0: shift shr left by 1, decrement bit_idx, set cyc=0.
  - At cyc==TBIT-1 with bit_idx==0: pulse pixel_done and go to REQ. ws2812_data_req rises on the next cycle, so there is a fresh rising edge per pixel.
- ws2812_data changes after capture have no effect on the pixel being sent.
- The inter-pixel low gap equals the upstream response time, at least 2 cycles. The block itself does not enforce a maximum gap.
- Pixel duration is 24*TBIT = 1512 cycles. There is no FIFO: exactly one word is in flight.
- Widths: cyc 8 bits, bit_idx 5 bits. Counters never exceed TBIT-1 or 23.

Test Plan:
- Reset release, no vld → IDLE for 1 cycle, then ws2812_data_req=1 from cycle 2 onward; ws2812_dout=0 and busy=0 throughout.
- Single pixel 24'hA5_00_FF, vld rises at cycle N:
  - req=0 and dout=1 at N+1.
  - Bit pattern 1010_0101_0000_0000_1111_1111 observed; high widths 40 (for '1') and 20 (for '0') cycles per 63-cycle slot.
  - pixel_done at N+1512; req=1 at N+1513.
- Back-to-back: source raises vld 2 cycles after each req rise for 3 pixels (000000, FFFFFF, 800001) → each word serialized correctly; 3 pixel_done pulses; inter-pixel low gap of 2-3 cycles.
- Stale vld:
  - vld held high continuously across a pixel end → no second capture; req stays 1 and dout stays 0 for 30000 cycles.
  - A later vld drop and re-rise → capture.
- Data change mid-pixel: ws2812_data toggles every cycle during SEND → transmitted bits equal the word captured at the vld rise.
- Reset mid-bit: assert rst while dout=1 in bit 12 → dout=0 in the same cycle. After release: IDLE, then REQ; the next pixel is sent complete from bit 23.

Source files
------------

// File: rtl/ws2812_tx.sv
// WS2812 single-wire NRZ transmitter: requests one GRB word per pixel
// and shifts it out MSB-first as pulse-width coded bits.
module ws2812_tx #(
  parameter int         CLK_FREQ_HZ = 50_000_000,
  parameter logic [7:0] T0H         = 8'd20,
  parameter logic [7:0] T1H         = 8'd40,
  parameter logic [7:0] TBIT        = 8'd63
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ws2812_data_req,
  input  logic [23:0] ws2812_data,
  input  logic        ws2812_data_vld,
  output logic        ws2812_dout,
  output logic        busy,
  output logic        pixel_done
);

  if (CLK_FREQ_HZ <= 0 || T0H == 8'd0 || T0H >= T1H || T1H >= TBIT)
  begin : g_bad_param
    $error("ws2812_tx: invalid timing parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SEND
  } state_t;

  localparam logic [7:0] LAST_CYC = TBIT - 8'd1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_shr;
  logic [23:0] w_shr_nxt;
  logic [4:0]  r_bit_idx;
  logic [4:0]  w_bit_idx_nxt;
  logic [7:0]  r_cyc;
  logic [7:0]  w_cyc_nxt;
  logic        r_dout;
  logic        w_dout_nxt;
  logic        r_vld_d;
  logic        w_vld_rise;
  logic        w_last_cyc;
  logic        w_last_bit;

  assign w_vld_rise = ws2812_data_vld & ~r_vld_d;
  assign w_last_cyc = (r_cyc == LAST_CYC);
  assign w_last_bit = (r_bit_idx == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_vld_rise) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (w_last_cyc && w_last_bit) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ws2812_data_req = 1'b0;
    busy            = 1'b0;
    pixel_done      = 1'b0;
    unique case (r_state)
      S_REQ:  ws2812_data_req = 1'b1;
      S_SEND: begin
        busy       = 1'b1;
        pixel_done = w_last_cyc & w_last_bit;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_shr_nxt     = r_shr;
    w_bit_idx_nxt = r_bit_idx;
    w_cyc_nxt     = r_cyc;
    unique case (r_state)
      S_REQ: begin
        if (w_vld_rise) begin
          w_shr_nxt     = ws2812_data;
          w_bit_idx_nxt = 5'd23;
          w_cyc_nxt     = 8'd0;
        end
      end
      S_SEND: begin
        if (!w_last_cyc) begin
          w_cyc_nxt = r_cyc + 8'd1;
        end else if (!w_last_bit) begin
          w_shr_nxt     = {r_shr[22:0], 1'b0};
          w_bit_idx_nxt = r_bit_idx - 5'd1;
          w_cyc_nxt     = 8'd0;
        end
      end
      default: ;
    endcase
  end

  // Line level is computed from next-cycle state so the register
  // output lines up with the cycle count it describes.
  always_comb begin
    w_dout_nxt = 1'b0;
    if (w_state_nxt == S_SEND) begin
      w_dout_nxt = (w_cyc_nxt < (w_shr_nxt[23] ? T1H : T0H));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shr     <= 24'd0;
      r_bit_idx <= 5'd0;
      r_cyc     <= 8'd0;
      r_dout    <= 1'b0;
      r_vld_d   <= 1'b0;
    end else begin
      r_shr     <= w_shr_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_cyc     <= w_cyc_nxt;
      r_dout    <= w_dout_nxt;
      r_vld_d   <= ws2812_data_vld;
    end
  end

  assign ws2812_dout = r_dout;

endmodule
